// File: rtl/btn_pkg.sv
// Shared defaults, widths and FSM state type for the button event arbiter.
package btn_pkg;
   localparam int N_BTN_DEF      = 5;
   localparam int DEB_CYCLES_DEF = 50000;
   localparam int CODE_W         = 3;
   localparam int CNT_W          = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } arb_state_e;
endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer, stability counter and debounced level.
// press is high in the cycle before the edge that accepts a 0->1 level change.
module btn_debounce #(
   parameter int DEB_CYCLES = btn_pkg::DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);
   import btn_pkg::*;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   assign accept = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
   assign press  = accept && sync2_q;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q + 1'b1;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (accept) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/btn_event_arbiter.sv
// Debounces N_BTN buttons, queues one pending press per button and offers them
// to a valid/ready consumer in round-robin order; lost presses set a sticky flag.
module btn_event_arbiter #(
   parameter int N_BTN      = btn_pkg::N_BTN_DEF,
   parameter int DEB_CYCLES = btn_pkg::DEB_CYCLES_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_BTN-1:0]            btn,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [btn_pkg::CODE_W-1:0]  evt_code,
   output logic                        evt_drop
);
   import btn_pkg::*;

   logic [N_BTN-1:0]  press;
   logic [N_BTN-1:0]  pending_q, pending_d;
   logic [N_BTN-1:0]  clear_mask;
   logic              drop_now;
   arb_state_e        state_q;
   logic              valid_q, drop_q;
   logic [CODE_W-1:0] code_q, last_grant_q;
   logic [CODE_W-1:0] grant_idx, hi_idx;
   logic              grant_any, hi_found, grant_en;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_deb
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk     (clk),
         .rst     (rst),
         .btn_raw (btn[gi]),
         .press   (press[gi])
      );
   end

   // Lowest pending index above last_grant wins; otherwise wrap to lowest overall.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      hi_found  = 1'b0;
      hi_idx    = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            grant_any = 1'b1;
            grant_idx = CODE_W'(i);
            if (CODE_W'(i) > last_grant_q) begin
               hi_found = 1'b1;
               hi_idx   = CODE_W'(i);
            end
         end
      end
      if (hi_found) grant_idx = hi_idx;
   end

   assign grant_en = grant_any && ((state_q == ST_IDLE) || evt_ready);

   always_comb begin
      clear_mask = '0;
      for (int i = 0; i < N_BTN; i++) begin
         clear_mask[i] = grant_en && (grant_idx == CODE_W'(i));
      end
   end

   // A fresh press re-arms a bit that is being granted this cycle, so no loss there.
   assign pending_d = (pending_q & ~clear_mask) | press;
   assign drop_now  = |(press & pending_q & ~clear_mask);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         valid_q      <= 1'b0;
         code_q       <= '0;
         drop_q       <= 1'b0;
         pending_q    <= '0;
         last_grant_q <= CODE_W'(N_BTN - 1);
      end else begin
         pending_q <= pending_d;
         drop_q    <= drop_q | drop_now;
         case (state_q)
            ST_IDLE: begin
               if (grant_en) begin
                  code_q       <= grant_idx;
                  last_grant_q <= grant_idx;
                  valid_q      <= 1'b1;
                  state_q      <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (evt_ready) begin
                  if (grant_en) begin
                     code_q       <= grant_idx;
                     last_grant_q <= grant_idx;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign evt_valid = valid_q;
   assign evt_code  = code_q;
   assign evt_drop  = drop_q;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with DEB_CYCLES=4, N_BTN=5.
module tb_btn_event_arbiter;
   localparam int NB  = 5;
   localparam int DEB = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          evt_ready = 1'b1;
   logic [NB-1:0] btn = '0;
   logic          evt_valid, evt_drop;
   logic [2:0]    evt_code;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic          rst;
      logic [NB-1:0] btn;
      logic          ready;
      logic          exp_valid;
      logic [2:0]    exp_code;
      logic          chk_code;
      logic          exp_drop;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   btn_event_arbiter #(.N_BTN(NB), .DEB_CYCLES(DEB)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_code  (evt_code),
      .evt_drop  (evt_drop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic [NB-1:0] b, input logic rd,
                      input logic ev, input logic [2:0] ec, input logic cc,
                      input logic ed, input int n);
      vec_t v;
      v.rst = r; v.btn = b; v.ready = rd;
      v.exp_valid = ev; v.exp_code = ec; v.chk_code = cc; v.exp_drop = ed;
      repeat (n) vecs.push_back(v);
   endtask

   task automatic offer_cycles(input int n, input logic [2:0] code, input string tag);
      repeat (n) begin
         tick();
         chk({tag, "_valid"}, evt_valid, 1);
         chk({tag, "_code"}, evt_code, code);
      end
   endtask

   initial begin
      // reset, 3-cycle glitch, then a held press and its release
      add(1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 2);
      add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1);
      add(1'b0, 5'b00100, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3);
      add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 6);
      add(1'b0, 5'b00100, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 6);
      add(1'b0, 5'b00100, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1);
      add(1'b0, 5'b00100, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4);
      add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 9);

      for (int k = 0; k < vecs.size(); k++) begin
         rst       = vecs[k].rst;
         btn       = vecs[k].btn;
         evt_ready = vecs[k].ready;
         tick();
         $display("vec %0d: rst=%0b btn=%b ready=%0b -> valid=%0b code=%0d drop=%0b",
                  k, rst, btn, evt_ready, evt_valid, evt_code, evt_drop);
         chk("vec_valid", evt_valid, vecs[k].exp_valid);
         chk("vec_drop", evt_drop, vecs[k].exp_drop);
         if (vecs[k].chk_code) chk("vec_code", evt_code, vecs[k].exp_code);
      end

      // back-to-back grants 0,1,4 from a simultaneous acceptance
      rst = 1'b1; btn = '0; evt_ready = 1'b1;
      tick();
      rst = 1'b0; btn = 5'b10011;
      repeat (6) tick();
      chk("b2b_pre_valid", evt_valid, 0);
      chk("b2b_pending", dut.pending_q, 5'b10011);
      tick(); chk("b2b_v0", evt_valid, 1); chk("b2b_c0", evt_code, 0);
      $display("b2b event code=%0d", evt_code);
      tick(); chk("b2b_v1", evt_valid, 1); chk("b2b_c1", evt_code, 1);
      $display("b2b event code=%0d", evt_code);
      tick(); chk("b2b_v4", evt_valid, 1); chk("b2b_c4", evt_code, 4);
      $display("b2b event code=%0d", evt_code);
      tick(); chk("b2b_end", evt_valid, 0);
      btn = '0;
      repeat (12) begin
         tick();
         chk("b2b_release", evt_valid, 0);
      end

      // stalled offer of code 3, second press queues, third press is dropped
      rst = 1'b1;
      tick();
      rst = 1'b0; evt_ready = 1'b0; btn = 5'b01000;
      repeat (7) tick();
      chk("hold_first_valid", evt_valid, 1);
      chk("hold_first_code", evt_code, 3);
      btn = '0;       offer_cycles(6, 3'd3, "hold");
      btn = 5'b01000; offer_cycles(6, 3'd3, "hold");
      chk("hold_pending2", dut.pending_q, 5'b01000);
      chk("hold_drop2", evt_drop, 0);
      btn = '0;       offer_cycles(6, 3'd3, "hold");
      btn = 5'b01000; offer_cycles(5, 3'd3, "hold");
      chk("hold_drop_pre", evt_drop, 0);
      offer_cycles(1, 3'd3, "hold");
      chk("hold_drop3", evt_drop, 1);
      chk("hold_pending3", dut.pending_q, 5'b01000);
      $display("stall: drop=%0d pending=%b", evt_drop, dut.pending_q);
      evt_ready = 1'b1;
      tick(); chk("rearm_valid", evt_valid, 1); chk("rearm_code", evt_code, 3);
      tick(); chk("rearm_end", evt_valid, 0); chk("rearm_pending", dut.pending_q, 0);
      chk("rearm_drop_sticky", evt_drop, 1);
      btn = '0;

      // round robin: last grant 0, buttons 0 and 1 both pending -> 1 next
      rst = 1'b1;
      tick();
      rst = 1'b0; evt_ready = 1'b0; btn = 5'b00001;
      repeat (7) tick();
      chk("rr_first_valid", evt_valid, 1);
      chk("rr_first_code", evt_code, 0);
      btn = '0;       repeat (6) tick();
      btn = 5'b00011; repeat (6) tick();
      chk("rr_pending", dut.pending_q, 5'b00011);
      evt_ready = 1'b1;
      tick(); chk("rr_next_valid", evt_valid, 1); chk("rr_next_code", evt_code, 1);
      $display("rr event code=%0d", evt_code);
      tick(); chk("rr_then_code", evt_code, 0);
      tick(); chk("rr_end", evt_valid, 0); chk("rr_drop", evt_drop, 0);

      // reset during an offer with another event still pending
      rst = 1'b1; btn = '0;
      tick();
      rst = 1'b0; evt_ready = 1'b0; btn = 5'b00110;
      repeat (7) tick();
      chk("rst_offer_code", evt_code, 1);
      chk("rst_offer_pending", dut.pending_q, 5'b00100);
      rst = 1'b1;
      tick();
      chk("rst_valid", evt_valid, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_drop", evt_drop, 0);
      chk("rst_pending", dut.pending_q, 0);
      rst = 1'b0; btn = '0; evt_ready = 1'b1;
      repeat (15) begin
         tick();
         chk("no_stale", evt_valid, 0);
      end

      // button held through reset release yields a press after debounce
      rst = 1'b1; btn = 5'b00100;
      tick(); tick();
      rst = 1'b0;
      repeat (6) tick();
      chk("held_rst_pre", evt_valid, 0);
      tick();
      chk("held_rst_valid", evt_valid, 1);
      chk("held_rst_code", evt_code, 2);
      tick();
      chk("held_rst_end", evt_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
